// File: rtl/mult_result_bcd.sv
// Result stage for the 8x8 multiplier: captures the product on a done_flag rising
// edge and converts it to five packed BCD digits, one double-dabble step per clock.
module mult_result_bcd (
  input  logic        clk,
  input  logic        reset_a,
  input  logic        done_flag,
  input  logic [15:0] product_in,
  output logic [19:0] bcd_out,
  output logic        bcd_valid,
  output logic        busy,
  output logic [4:0]  blank_mask,
  output logic        overrun
);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t      state;
  logic        done_d;
  logic [15:0] bin_sr;
  logic [19:0] acc;
  logic [3:0]  cnt;

  logic        req;
  logic [19:0] acc_adj;
  logic [35:0] shifted;
  logic [19:0] acc_next;
  logic [15:0] bin_next;
  logic [4:0]  mask_next;
  logic        zero_run;

  assign req = done_flag & ~done_d;

  // One double-dabble step: add-3 adjust on every digit, then shift the binary
  // MSB into the accumulator.
  always_comb begin
    acc_adj = acc;
    for (int unsigned i = 0; i < 5; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    shifted  = {acc_adj, bin_sr} << 1;
    acc_next = shifted[35:16];
    bin_next = shifted[15:0];
  end

  // Leading-zero mask: a digit blanks only while it and every higher digit are 0.
  always_comb begin
    zero_run  = 1'b1;
    mask_next = '0;
    for (int unsigned i = 4; i >= 1; i--) begin
      zero_run     = zero_run & (acc_next[4*i +: 4] == 4'd0);
      mask_next[i] = zero_run;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_a) begin
      state      <= IDLE;
      done_d     <= 1'b1;
      bin_sr     <= '0;
      acc        <= '0;
      cnt        <= '0;
      bcd_out    <= '0;
      blank_mask <= 5'b11110;
      bcd_valid  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      done_d    <= done_flag;
      bcd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            bin_sr  <= product_in;
            acc     <= '0;
            cnt     <= '0;
            overrun <= 1'b0;
            busy    <= 1'b1;
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          if (req)
            overrun <= 1'b1;
          acc    <= acc_next;
          bin_sr <= bin_next;
          cnt    <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            bcd_out    <= acc_next;
            blank_mask <= mask_next;
            bcd_valid  <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_result_bcd.sv
// Scoreboard bench for mult_result_bcd: expected results are queued at capture and
// compared by an independent monitor whenever bcd_valid is presented.
module tb_mult_result_bcd;

  logic        clk = 1'b0;
  logic        reset_a;
  logic        done_flag;
  logic [15:0] product_in;
  logic [19:0] bcd_out;
  logic        bcd_valid;
  logic        busy;
  logic [4:0]  blank_mask;
  logic        overrun;

  mult_result_bcd dut (
    .clk        (clk),
    .reset_a    (reset_a),
    .done_flag  (done_flag),
    .product_in (product_in),
    .bcd_out    (bcd_out),
    .bcd_valid  (bcd_valid),
    .busy       (busy),
    .blank_mask (blank_mask),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] bcd;
    logic [4:0]  mask;
    logic        ovr;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   rst_window = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain decimal digit extraction.
  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    r = '0;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] mask_of(input int v);
    logic [4:0] m;
    int p;
    m = '0;
    p = 10;
    for (int i = 1; i <= 4; i++) begin
      if (v < p) m[i] = 1'b1;
      p = p * 10;
    end
    return m;
  endfunction

  // Monitor
  logic [19:0] prev_bcd;
  logic        prev_valid;
  int          busy_run;
  always @(negedge clk) begin
    exp_t e;
    if (rst_window) begin
      busy_run   = 0;
      prev_bcd   = bcd_out;
      prev_valid = 1'b0;
    end else begin
      if (bcd_valid) begin
        check("valid_single_cycle", 32'(prev_valid), 32'd0);
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("bcd_out", 32'(bcd_out), 32'(e.bcd));
          check("blank_mask", 32'(blank_mask), 32'(e.mask));
          check("overrun", 32'(overrun), 32'(e.ovr));
          check("valid_latency", 32'(cyc), 32'(e.due));
          check("busy_cycles", 32'(busy_run), 32'd16);
          check("busy_low_at_valid", 32'(busy), 32'd0);
        end
      end else if (bcd_out !== prev_bcd) begin
        check("bcd_out_stable", 32'(bcd_out), 32'(prev_bcd));
      end
      busy_run   = busy ? busy_run + 1 : 0;
      prev_bcd   = bcd_out;
      prev_valid = bcd_valid;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after an edge with done_flag low; raises a request sampled at E0.
  // ovr_at (2..16) injects a second rising edge sampled at that shift edge.
  task automatic capture(input logic [15:0] val, input logic [15:0] after, input int ovr_at);
    exp_t e;
    product_in = val;
    done_flag  = 1'b1;
    step(1);
    e.bcd  = to_bcd(int'(val));
    e.mask = mask_of(int'(val));
    e.ovr  = (ovr_at != 0);
    e.due  = cyc + 16;
    sb.push_back(e);
    product_in = after;
    for (int k = 1; k <= 16; k++) begin
      done_flag = (ovr_at == k);
      step(1);
    end
    done_flag = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bcd_out"}, 32'(bcd_out), 32'd0);
    check({tag, "_blank_mask"}, 32'(blank_mask), 32'b11110);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(bcd_valid), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation timed out, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_a    = 1'b1;
    done_flag  = 1'b1;
    product_in = 16'h0000;
    step(3);
    reset_a = 1'b0;
    check_reset_values("reset");
    step(5);
    check("no_capture_high_at_release", 32'(busy), 32'd0);
    done_flag = 1'b0;
    step(1);
    rst_window = 1'b0;
    step(1);

    capture(16'hFE01, 16'hFE01, 0);
    step(2);
    capture(16'h0000, 16'h0000, 0);
    step(1);
    capture(16'h002A, 16'h002A, 0);
    step(1);
    capture(16'hFFFF, 16'h1234, 0);
    step(2);
    capture(16'h270F, 16'h0000, 5);
    step(2);
    check("overrun_sticky", 32'(overrun), 32'd1);
    capture(16'h0001, 16'h0000, 0);
    step(1);
    check("overrun_cleared", 32'(overrun), 32'd0);

    // Reset one cycle at E8 of a conversion, done_flag held high through release
    product_in = 16'h1234;
    done_flag  = 1'b1;
    step(1);
    done_flag = 1'b0;
    step(7);
    rst_window = 1'b1;
    reset_a    = 1'b1;
    done_flag  = 1'b1;
    step(1);
    reset_a = 1'b0;
    sb.delete();
    check_reset_values("midreset");
    step(1);
    rst_window = 1'b0;
    step(20);
    check("no_capture_after_midreset", 32'(busy), 32'd0);
    done_flag = 1'b0;
    step(1);

    // Back-to-back captures 17 clocks apart
    capture(16'h0064, 16'h0000, 0);
    capture(16'h0190, 16'h0000, 0);
    step(2);
    check("b2b_overrun", 32'(overrun), 32'd0);

    for (int n = 0; n < 40; n++) begin
      logic [15:0] v, a;
      int o;
      v = 16'($urandom);
      a = 16'($urandom);
      o = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 16)) : 0;
      capture(v, a, o);
      step(int'($urandom_range(0, 3)));
    end

    step(5);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
